// File: rtl/perf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : perf_pkg
// Brief    : Shared types and counter-step helper for the performance monitor.
// Revision : 1.0 - initial multi-channel windowed release
// ============================================================================
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } perf_state_t;

    localparam int DEFAULT_COUNTER_WIDTH = 32;
    localparam int MAX_COUNTER_WIDTH     = 64;

    typedef struct packed {
        logic                         ovf;
        logic [MAX_COUNTER_WIDTH-1:0] value;
    } count_step_t;

    // Width-agnostic: callers pass their all-ones value zero-extended to 64 bits.
    function automatic count_step_t count_step(
        input logic [MAX_COUNTER_WIDTH-1:0] cur,
        input logic [MAX_COUNTER_WIDTH-1:0] all_ones,
        input logic                         sat
    );
        count_step_t r;
        r.ovf = (cur == all_ones);
        if (!r.ovf) begin
            r.value = cur + 64'd1;
        end else if (sat) begin
            r.value = all_ones;
        end else begin
            r.value = '0;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/perf_event_counter.sv
`default_nettype none
// ============================================================================
// Module   : perf_event_counter
// Brief    : Single event counter with sticky overflow, saturate or wrap.
// Revision : 1.0 - initial multi-channel windowed release
// ============================================================================
module perf_event_counter
    import perf_pkg::*;
#(
    parameter int WIDTH = DEFAULT_COUNTER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] count,
    output logic             ovf
);

    localparam logic [MAX_COUNTER_WIDTH-1:0] c_ALL_ONES = MAX_COUNTER_WIDTH'({WIDTH{1'b1}});

    logic [WIDTH-1:0] r_count;
    logic             r_ovf;
    count_step_t      w_step;

    assign w_step = count_step(MAX_COUNTER_WIDTH'(r_count), c_ALL_ONES, sat_mode);

    generate
        if (WIDTH < MAX_COUNTER_WIDTH) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^w_step.value[MAX_COUNTER_WIDTH-1:WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (inc) begin
            r_count <= w_step.value[WIDTH-1:0];
            r_ovf   <= r_ovf | w_step.ovf;
        end
    end

    assign count = r_count;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: rtl/perf_monitor.sv
`default_nettype none
// ============================================================================
// Module   : perf_monitor
// Brief    : Windowed multi-channel event/cycle counter with indexed readout.
// Revision : 1.0 - initial multi-channel windowed release
// ============================================================================
module perf_monitor
    import perf_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
    parameter int SATURATE      = 1,
    parameter int SEL_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     clear,
    input  logic [COUNTER_WIDTH-1:0] window_len,
    input  logic [NUM_CH-1:0]        events,
    input  logic [SEL_W-1:0]         rd_sel,
    output logic [COUNTER_WIDTH-1:0] rd_count,
    output logic [COUNTER_WIDTH-1:0] cycles_elapsed,
    output logic                     running,
    output logic                     done,
    output logic [NUM_CH-1:0]        overflow,
    output logic                     cycle_overflow
);

    perf_state_t              r_state;
    perf_state_t              w_state_nxt;
    logic [COUNTER_WIDTH-1:0] r_window;
    logic                     w_in_run;
    logic                     w_arm;
    logic                     w_clr_cnt;
    logic                     w_sat;
    logic                     w_auto_stop;
    logic [COUNTER_WIDTH-1:0] w_cyc_inc;
    logic [COUNTER_WIDTH-1:0] w_counts [NUM_CH];

    assign w_in_run  = (r_state == RUN);
    // start only arms from IDLE or DONE; a start during RUN is ignored
    assign w_arm     = start && !w_in_run && !clear;
    assign w_clr_cnt = clear || w_arm;
    assign w_sat     = (SATURATE != 0);

    // Compare against the post-increment count so exactly window_len cycles land
    assign w_cyc_inc   = cycles_elapsed + COUNTER_WIDTH'(1);
    assign w_auto_stop = w_in_run && (r_window != '0) && (w_cyc_inc == r_window);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        running     = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = RUN;
            end
            RUN: begin
                running = 1'b1;
                if (stop || w_auto_stop) w_state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) w_state_nxt = RUN;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (clear) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_window <= '0;
        end else if (clear) begin
            r_window <= '0;
        end else if (w_arm) begin
            r_window <= window_len;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            perf_event_counter #(
                .WIDTH (COUNTER_WIDTH)
            ) u_cnt (
                .clk      (clk),
                .rst_n    (rst_n),
                .clr      (w_clr_cnt),
                .inc      (events[gi] && w_in_run),
                .sat_mode (w_sat),
                .count    (w_counts[gi]),
                .ovf      (overflow[gi])
            );
        end
    endgenerate

    perf_event_counter #(
        .WIDTH (COUNTER_WIDTH)
    ) u_cycle_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (w_clr_cnt),
        .inc      (w_in_run),
        .sat_mode (w_sat),
        .count    (cycles_elapsed),
        .ovf      (cycle_overflow)
    );

    // Selects that match no channel read back as zero
    always_comb begin
        rd_count = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == SEL_W'(i)) rd_count = w_counts[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_perf_monitor
// Brief    : Self-checking bench for perf_monitor against a behavioural model.
// Revision : 1.0 - initial multi-channel windowed release
// ============================================================================
module tb_perf_monitor;

    localparam int     NCH  = 4;
    localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // main instance: 4 channels, 32-bit, saturating
    logic        start, stop, clear;
    logic [31:0] window_len;
    logic [3:0]  events;
    logic [1:0]  rd_sel;
    logic [31:0] rd_count, cycles_elapsed;
    logic        running, done, cycle_overflow;
    logic [3:0]  overflow;

    // two 4-bit instances, saturating and wrapping, sharing their stimulus
    logic        start4, stop4, clear4;
    logic [3:0]  win4, events4;
    logic [1:0]  rd_sel4;
    logic [3:0]  s_rd, s_cyc, s_ovf, w_rd, w_cyc, w_ovf;
    logic        s_run, s_done, s_covf, w_run, w_done, w_covf;

    int n_checks = 0;
    int n_errors = 0;

    perf_monitor #(.NUM_CH(4), .COUNTER_WIDTH(32), .SATURATE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
        .window_len(window_len), .events(events), .rd_sel(rd_sel),
        .rd_count(rd_count), .cycles_elapsed(cycles_elapsed), .running(running),
        .done(done), .overflow(overflow), .cycle_overflow(cycle_overflow)
    );

    perf_monitor #(.NUM_CH(4), .COUNTER_WIDTH(4), .SATURATE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start4), .stop(stop4), .clear(clear4),
        .window_len(win4), .events(events4), .rd_sel(rd_sel4),
        .rd_count(s_rd), .cycles_elapsed(s_cyc), .running(s_run),
        .done(s_done), .overflow(s_ovf), .cycle_overflow(s_covf)
    );

    perf_monitor #(.NUM_CH(4), .COUNTER_WIDTH(4), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start4), .stop(stop4), .clear(clear4),
        .window_len(win4), .events(events4), .rd_sel(rd_sel4),
        .rd_count(w_rd), .cycles_elapsed(w_cyc), .running(w_run),
        .done(w_done), .overflow(w_ovf), .cycle_overflow(w_covf)
    );

    // Behavioural model of the main instance: 0 = idle, 1 = measuring, 2 = finished
    int     m_phase;
    longint m_cnt [NCH];
    longint m_cyc;
    longint m_win;
    bit     m_ovf [NCH];
    bit     m_covf;

    function automatic longint bump(input longint v);
        return (v == MAXV) ? MAXV : v + 1;
    endfunction

    task automatic model_zero();
        m_cyc  = 0;
        m_covf = 0;
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 0;
            m_ovf[i] = 0;
        end
    endtask

    task automatic model_reset();
        model_zero();
        m_phase = 0;
        m_win   = 0;
    endtask

    task automatic model_step();
        if (clear) begin
            model_zero();
            m_phase = 0;
            m_win   = 0;
        end else if (start && m_phase != 1) begin
            model_zero();
            m_phase = 1;
            m_win   = longint'(window_len);
        end else if (m_phase == 1) begin
            if (m_cyc == MAXV) m_covf = 1;
            m_cyc = bump(m_cyc);
            for (int i = 0; i < NCH; i++) begin
                if (events[i]) begin
                    if (m_cnt[i] == MAXV) m_ovf[i] = 1;
                    m_cnt[i] = bump(m_cnt[i]);
                end
            end
            if (stop || (m_win != 0 && m_cyc == m_win)) m_phase = 2;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] model_ovf_vec();
        logic [3:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_ovf[i];
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        {start, stop, clear} = 3'b000;
        {start4, stop4, clear4} = 3'b000;
        window_len = 32'd0;
        win4 = 4'd0;
        events = 4'hF;
        events4 = 4'hF;
        rd_sel = 2'd0;
        rd_sel4 = 2'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) tick();
        n_checks++;
        if (running !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: running=%b done=%b, expected 0 0", running, done);
        end
        n_checks++;
        if (overflow !== 4'h0 || cycle_overflow !== 1'b0 || cycles_elapsed !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_counts: ovf=%h covf=%b cyc=%0d, expected 0 0 0",
                     overflow, cycle_overflow, cycles_elapsed);
        end
        for (int i = 0; i < NCH; i++) begin
            rd_sel = 2'(i);
            #1;
            n_checks++;
            if (rd_count !== 32'd0) begin
                n_errors++;
                $display("FAIL reset_ch%0d: got %0d expected 0", i, rd_count);
            end
        end
    endtask

    task automatic test_manual_stop();
        events = 4'h0;
        window_len = 32'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            events = {2'($urandom), (k % 2 == 1), 1'b1};
            stop = (k == 10);
            tick();
        end
        stop = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            n_checks++;
            if (done !== 1'b1 || running !== 1'b0 || cycles_elapsed !== 32'd10
                || longint'(cycles_elapsed) != m_cyc) begin
                n_errors++;
                $display("FAIL stop_state pass%0d: done=%b running=%b cyc=%0d, expected 1 0 10",
                         pass, done, running, cycles_elapsed);
            end
            rd_sel = 2'd0; #1;
            n_checks++;
            if (rd_count !== 32'd10) begin
                n_errors++;
                $display("FAIL stop_ch0 pass%0d: got %0d expected 10", pass, rd_count);
            end
            rd_sel = 2'd1; #1;
            n_checks++;
            if (rd_count !== 32'd5) begin
                n_errors++;
                $display("FAIL stop_ch1 pass%0d: got %0d expected 5", pass, rd_count);
            end
            for (int i = 2; i < NCH; i++) begin
                rd_sel = 2'(i); #1;
                n_checks++;
                if (rd_count !== 32'(m_cnt[i])) begin
                    n_errors++;
                    $display("FAIL stop_ch%0d pass%0d: got %0d expected %0d", i, pass, rd_count, m_cnt[i]);
                end
            end
            if (pass == 0) begin
                for (int k = 0; k < 20; k++) begin
                    events = 4'($urandom);
                    stop = ($urandom_range(0, 3) == 0);
                    tick();
                end
                stop = 1'b0;
            end
        end
    endtask

    task automatic test_auto_stop();
        int n;
        window_len = 32'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        window_len = $urandom;
        n = 0;
        n_checks++;
        if (running !== 1'b1) begin
            n_errors++;
            $display("FAIL auto_enter: running=%b expected 1", running);
        end
        while (running === 1'b1 && n < 200) begin
            events = {1'($urandom), 1'b1, 2'($urandom)};
            tick();
            n++;
        end
        n_checks++;
        if (n != 100 || done !== 1'b1) begin
            n_errors++;
            $display("FAIL auto_len: ran %0d cycles done=%b, expected 100 1", n, done);
        end
        n_checks++;
        if (cycles_elapsed !== 32'd100) begin
            n_errors++;
            $display("FAIL auto_cycles: got %0d expected 100", cycles_elapsed);
        end
        rd_sel = 2'd2; #1;
        n_checks++;
        if (rd_count !== 32'd100) begin
            n_errors++;
            $display("FAIL auto_ch2: got %0d expected 100", rd_count);
        end
    endtask

    task automatic test_saturate_wrap();
        events = 4'h0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            events4 = {3'($urandom), 1'b1};
            stop4 = (k == 20);
            tick();
        end
        stop4 = 1'b0;
        rd_sel4 = 2'd0;
        #1;
        n_checks++;
        if (s_rd !== 4'd15 || s_ovf[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_ch0: count=%0d ovf0=%b expected 15 1", s_rd, s_ovf[0]);
        end
        n_checks++;
        if (s_cyc !== 4'd15 || s_covf !== 1'b1 || s_done !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_cycle: cyc=%0d covf=%b done=%b expected 15 1 1", s_cyc, s_covf, s_done);
        end
        n_checks++;
        if (w_rd !== 4'd4 || w_ovf[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_ch0: count=%0d ovf0=%b expected 4 1", w_rd, w_ovf[0]);
        end
        n_checks++;
        if (w_cyc !== 4'd4 || w_covf !== 1'b1 || w_done !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_cycle: cyc=%0d covf=%b done=%b expected 4 1 1", w_cyc, w_covf, w_done);
        end
    endtask

    task automatic test_rearm();
        start = 1'b1;
        start4 = 1'b1;
        window_len = 32'd0;
        tick();
        start = 1'b0;
        start4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            events = 4'($urandom);
            events4 = 4'b0001;
            stop4 = (k == 2);
            tick();
        end
        stop4 = 1'b0;
        events4 = 4'h0;
        n_checks++;
        if (s_rd !== 4'd3 || s_ovf !== 4'h0 || s_covf !== 1'b0) begin
            n_errors++;
            $display("FAIL rearm_sat: count=%0d ovf=%h covf=%b expected 3 0 0", s_rd, s_ovf, s_covf);
        end
        n_checks++;
        if (w_rd !== 4'd3 || w_ovf !== 4'h0 || w_covf !== 1'b0 || w_cyc !== 4'd3) begin
            n_errors++;
            $display("FAIL rearm_wrap: count=%0d ovf=%h covf=%b cyc=%0d expected 3 0 0 3",
                     w_rd, w_ovf, w_covf, w_cyc);
        end
        n_checks++;
        if (running !== 1'b1 || cycles_elapsed !== 32'd3) begin
            n_errors++;
            $display("FAIL rearm_main: running=%b cyc=%0d expected 1 3", running, cycles_elapsed);
        end
        for (int i = 0; i < NCH; i++) begin
            rd_sel = 2'(i); #1;
            n_checks++;
            if (rd_count !== 32'(m_cnt[i])) begin
                n_errors++;
                $display("FAIL rearm_ch%0d: got %0d expected %0d", i, rd_count, m_cnt[i]);
            end
        end
    endtask

    task automatic test_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            events = 4'($urandom);
            clear = (k == 7);
            tick();
        end
        clear = 1'b0;
        n_checks++;
        if (running !== 1'b0 || done !== 1'b0 || cycles_elapsed !== 32'd0 || overflow !== 4'h0) begin
            n_errors++;
            $display("FAIL clear_state: running=%b done=%b cyc=%0d ovf=%h expected 0 0 0 0",
                     running, done, cycles_elapsed, overflow);
        end
        for (int i = 0; i < NCH; i++) begin
            rd_sel = 2'(i); #1;
            n_checks++;
            if (rd_count !== 32'd0) begin
                n_errors++;
                $display("FAIL clear_ch%0d: got %0d expected 0", i, rd_count);
            end
        end
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        n_checks++;
        if (running !== 1'b1) begin
            n_errors++;
            $display("FAIL start_stop_same: running=%b expected 1", running);
        end
        for (int k = 0; k < 5; k++) begin
            events = 4'($urandom);
            tick();
        end
        n_checks++;
        if (cycles_elapsed !== 32'd5 || longint'(cycles_elapsed) != m_cyc) begin
            n_errors++;
            $display("FAIL start_stop_cycles: got %0d expected 5", cycles_elapsed);
        end
        for (int i = 0; i < NCH; i++) begin
            rd_sel = 2'(i); #1;
            n_checks++;
            if (rd_count !== 32'(m_cnt[i])) begin
                n_errors++;
                $display("FAIL start_stop_ch%0d: got %0d expected %0d", i, rd_count, m_cnt[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) begin
            events = 4'hF;
            tick();
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (running !== 1'b0 || done !== 1'b0 || cycles_elapsed !== 32'd0
            || overflow !== 4'h0 || cycle_overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: running=%b done=%b cyc=%0d ovf=%h covf=%b expected all 0",
                     running, done, cycles_elapsed, overflow, cycle_overflow);
        end
        for (int i = 0; i < NCH; i++) begin
            rd_sel = 2'(i); #1;
            n_checks++;
            if (rd_count !== 32'd0) begin
                n_errors++;
                $display("FAIL async_reset_ch%0d: got %0d expected 0", i, rd_count);
            end
        end
        #1;
        rst_n = 1'b1;
        events = 4'h0;
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            events = 4'($urandom);
            start = ($urandom_range(0, 7) == 0);
            stop = ($urandom_range(0, 9) == 0);
            clear = ($urandom_range(0, 49) == 0);
            window_len = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(1, 15));
            rd_sel = 2'($urandom);
            tick();
            n_checks++;
            if (running !== (m_phase == 1) || done !== (m_phase == 2)
                || cycles_elapsed !== 32'(m_cyc)) begin
                n_errors++;
                $display("FAIL random_state@%0d: running=%b done=%b cyc=%0d expected %b %b %0d",
                         k, running, done, cycles_elapsed, (m_phase == 1), (m_phase == 2), m_cyc);
            end
            n_checks++;
            if (rd_count !== 32'(m_cnt[rd_sel]) || overflow !== model_ovf_vec()
                || cycle_overflow !== m_covf) begin
                n_errors++;
                $display("FAIL random_count@%0d: ch%0d=%0d ovf=%h covf=%b expected %0d %h %b",
                         k, rd_sel, rd_count, overflow, cycle_overflow,
                         m_cnt[rd_sel], model_ovf_vec(), m_covf);
            end
        end
        {start, stop, clear} = 3'b000;
    endtask

    initial begin
        test_reset();
        test_manual_stop();
        test_auto_stop();
        test_saturate_wrap();
        test_rearm();
        test_clear();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
